// File: rtl/mem_arb.sv
// Two-master Wishbone classic arbiter in front of a single memory slave port.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN; the default build uses fixed priority.
module mem_arb #(
  parameter int AW = 20,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic          m0_we_i,
  input  logic          m0_stb_i,
  input  logic          m0_byte_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic          m1_we_i,
  input  logic          m1_stb_i,
  input  logic          m1_byte_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  output logic          s_byte_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  // state | meaning
  // IDLE  | no owner, slave port quiet
  // GNT0  | master 0 owns the slave port
  // GNT1  | master 1 owns the slave port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } st_t;

  st_t st, st_nxt, st_out;

  always_ff @(posedge clk_i) begin
    if (rst_i) st <= IDLE;
    else       st <= st_nxt;
  end

`ifdef MEM_ARB_RR_EN
  logic last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last <= 1'b1;
    end else if (st_nxt == GNT0 && st != GNT0) begin
      last <= 1'b0;
    end else if (st_nxt == GNT1 && st != GNT1) begin
      last <= 1'b1;
    end
  end
`endif

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
`ifdef MEM_ARB_RR_EN
          st_nxt = last ? GNT0 : GNT1;
`else
          st_nxt = GNT0;
`endif
        end else if (m0_stb_i) begin
          st_nxt = GNT0;
        end else if (m1_stb_i) begin
          st_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_stb_i) begin
          st_nxt = IDLE;
        end
`ifdef MEM_ARB_RR_EN
        else if (s_ack_i && m1_stb_i) begin
          st_nxt = GNT1;
        end
`endif
      end
      GNT1: begin
        // m0 takes over only at a transfer boundary, never mid-transfer
        if (!m1_stb_i) begin
          st_nxt = IDLE;
        end else if (s_ack_i && m0_stb_i) begin
          st_nxt = GNT0;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Reset also silences the port in the same cycle so an aborted transfer can never be acked.
  always_comb begin
    st_out   = rst_i ? IDLE : st;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_byte_o = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    gnt_o    = 2'b00;
    case (st_out)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_stb_o  = m0_stb_i;
        s_byte_o = m0_byte_i;
        m0_ack_o = s_ack_i;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_stb_o  = m1_stb_i;
        s_byte_o = m1_byte_i;
        m1_ack_o = s_ack_i;
        gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: vector table, hand sequences and a randomized run against a reference model.
module tb_mem_arb;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [19:0] A0 = 20'h0F000;
  localparam logic [19:0] A1 = 20'h11111;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [19:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [15:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_we_i, m0_stb_i, m0_byte_i, m0_ack_o;
  logic        m1_we_i, m1_stb_i, m1_byte_i, m1_ack_o;
  logic        s_we_o, s_stb_o, s_byte_o, s_ack_i;
  logic [1:0]  gnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_arb #(.AW(20), .DW(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i),
    .m0_byte_i(m0_byte_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i),
    .m1_byte_i(m1_byte_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_byte_o(s_byte_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic r, input logic s0, input logic s1, input logic ack);
    rst_i = r; m0_stb_i = s0; m1_stb_i = s1; s_ack_i = ack;
  endtask

  typedef struct {
    logic        rst, s0, s1, ack;
    logic [1:0]  gnt;
    logic        sstb, a0, a1;
    logic [19:0] adr;
  } vec_t;
  vec_t tbl[14];

  // Reference model: owner 0 = nobody, 1 = master 0, 2 = master 1.
  int own, last_m;

  function automatic int other(input int m);
    return 3 - m;
  endfunction

  task automatic model_step(input logic r, input logic [1:0] req, input logic ack);
    int nxt;
    nxt = own;
    if (r) begin
      own = 0;
      last_m = 2;
      return;
    end
    if (own == 0) begin
      if (req == 2'b11) nxt = RR ? other(last_m) : 1;
      else if (req[0])  nxt = 1;
      else if (req[1])  nxt = 2;
    end else if (!req[own-1]) begin
      nxt = 0;
    end else if (ack && req[other(own)-1]) begin
      if (RR || own == 2) nxt = other(own);
    end
    if (nxt != 0 && nxt != own) last_m = nxt;
    own = nxt;
  endtask

  initial begin
    logic [1:0]  eg;
    logic [19:0] ea;
    logic [15:0] ed;
    logic        es, ew, eb;
    int          eo;

    drive(1, 0, 0, 0);
    m0_adr_i = A0; m1_adr_i = A1;
    m0_dat_i = 16'h1234; m1_dat_i = 16'h5678; s_dat_i = 16'h0;
    m0_we_i = 1; m1_we_i = 0; m0_byte_i = 0; m1_byte_i = 1;

    tbl[0]  = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 20'h0};
    tbl[1]  = '{1, 1, 1, 0, 2'b00, 0, 0, 0, 20'h0};
    tbl[2]  = '{0, 1, 1, 0, 2'b00, 0, 0, 0, 20'h0};
    tbl[3]  = '{0, 1, 1, 1, 2'b01, 1, 1, 0, A0};
    tbl[4]  = RR ? '{0, 1, 1, 1, 2'b10, 1, 0, 1, A1} : '{0, 1, 1, 1, 2'b01, 1, 1, 0, A0};
    tbl[5]  = '{0, 1, 1, 0, 2'b01, 1, 0, 0, A0};
    tbl[6]  = '{0, 0, 1, 0, 2'b01, 0, 0, 0, A0};
    tbl[7]  = '{0, 0, 1, 1, 2'b00, 0, 0, 0, 20'h0};
    tbl[8]  = '{0, 0, 1, 0, 2'b10, 1, 0, 0, A1};
    tbl[9]  = '{0, 1, 1, 0, 2'b10, 1, 0, 0, A1};
    tbl[10] = '{0, 1, 1, 1, 2'b10, 1, 0, 1, A1};
    tbl[11] = '{0, 1, 1, 0, 2'b01, 1, 0, 0, A0};
    tbl[12] = '{1, 1, 1, 1, 2'b00, 0, 0, 0, 20'h0};
    tbl[13] = '{0, 0, 0, 1, 2'b00, 0, 0, 0, 20'h0};

    #1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].s0, tbl[i].s1, tbl[i].ack);
      #2;
      chk($sformatf("vec%0d_gnt", i), gnt_o, tbl[i].gnt);
      chk($sformatf("vec%0d_s_stb", i), s_stb_o, tbl[i].sstb);
      chk($sformatf("vec%0d_m0_ack", i), m0_ack_o, tbl[i].a0);
      chk($sformatf("vec%0d_m1_ack", i), m1_ack_o, tbl[i].a1);
      chk($sformatf("vec%0d_s_adr", i), s_adr_o, tbl[i].adr);
      next_cycle();
    end

    // Single m0 read, slave acks two cycles after the strobe reaches it.
    drive(1, 0, 0, 0); next_cycle();
    drive(0, 1, 0, 0); m0_we_i = 0;
    for (int c = 0; c < 4; c++) begin
      s_ack_i = (c == 3);
      s_dat_i = (c == 3) ? 16'hBEEF : 16'h0000;
      #2;
      chk($sformatf("rd%0d_s_stb", c), s_stb_o, c != 0);
      chk($sformatf("rd%0d_m0_ack", c), m0_ack_o, c == 3);
      chk($sformatf("rd%0d_m1_ack", c), m1_ack_o, 1'b0);
      if (c > 0) chk($sformatf("rd%0d_s_adr", c), s_adr_o, A0);
      if (c == 3) chk("rd_m0_dat", m0_dat_o, 16'hBEEF);
      next_cycle();
    end

    // Preemption: m0 requests while m1 is mid-transfer, takes over right after m1's ack.
    drive(1, 0, 0, 0); next_cycle();
    drive(0, 0, 1, 0); next_cycle();
    m0_stb_i = 1;
    for (int c = 0; c < 4; c++) begin
      s_ack_i = (c == 3);
      #2;
      chk($sformatf("pre%0d_gnt", c), gnt_o, 2'b10);
      chk($sformatf("pre%0d_m1_ack", c), m1_ack_o, c == 3);
      chk($sformatf("pre%0d_m0_ack", c), m0_ack_o, 1'b0);
      next_cycle();
    end
    s_ack_i = 0; #2;
    chk("pre_take_gnt", gnt_o, 2'b01);
    chk("pre_take_adr", s_adr_o, A0);
    next_cycle();

    // Reset while m1 owns the bus; the late slave ack must be dropped.
    drive(1, 0, 0, 0); next_cycle();
    drive(0, 0, 1, 0); next_cycle(); next_cycle();
    drive(1, 0, 1, 0); #2;
    chk("rstmid_s_stb", s_stb_o, 1'b0);
    next_cycle();
    drive(0, 0, 1, 1); #2;
    chk("rstmid_gnt", gnt_o, 2'b00);
    chk("rstmid_s_stb_after", s_stb_o, 1'b0);
    chk("rstmid_acks", {m0_ack_o, m1_ack_o}, 2'b00);
    next_cycle();

    // Randomized run against the reference model.
    drive(1, 0, 0, 0); next_cycle();
    own = 0; last_m = 2;
    for (int n = 0; n < 3000; n++) begin
      rst_i     = ($urandom_range(0, 40) == 0);
      m0_stb_i  = $urandom_range(0, 3) != 0;
      m1_stb_i  = $urandom_range(0, 3) != 0;
      s_ack_i   = $urandom_range(0, 2) == 0;
      m0_adr_i  = 20'($urandom); m1_adr_i = 20'($urandom);
      m0_dat_i  = 16'($urandom); m1_dat_i = 16'($urandom);
      s_dat_i   = 16'($urandom);
      m0_we_i   = 1'($urandom); m1_we_i = 1'($urandom);
      m0_byte_i = 1'($urandom); m1_byte_i = 1'($urandom);
      #2;
      eo = rst_i ? 0 : own;
      eg = 2'b00; es = 0; ea = '0; ed = '0; ew = 0; eb = 0;
      if (eo == 1) begin
        eg = 2'b01; es = m0_stb_i; ea = m0_adr_i; ed = m0_dat_i; ew = m0_we_i; eb = m0_byte_i;
      end else if (eo == 2) begin
        eg = 2'b10; es = m1_stb_i; ea = m1_adr_i; ed = m1_dat_i; ew = m1_we_i; eb = m1_byte_i;
      end
      chk($sformatf("rand%0d", n),
          {gnt_o, s_stb_o, s_adr_o, s_dat_o, s_we_o, s_byte_o, m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o},
          {eg, es, ea, ed, ew, eb, s_ack_i && eo == 1, s_ack_i && eo == 2, s_dat_i, s_dat_i});
      model_step(rst_i, {m1_stb_i, m0_stb_i}, s_ack_i);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
